arb_byte_packer: RTL and testbench
==================================

# arb_byte_packer

Downstream stage of the round-robin FIFO arbiter. Consumes the arbiter's 8-bit `dout`/`valid` byte stream, packs consecutive bytes little-endian into 32-bit words, and buffers completed words in a small output FIFO with a ready/valid handshake toward the next consumer. The arbiter has no backpressure input, so when the output FIFO cannot accept a word, the packer drops that word and records the loss in a sticky flag.

## Interface
- `BYTES`, 4, bytes per packed word. Fixed at 4 for this revision.
- `DEPTH`, 2, output FIFO entries. Must be a power of 2, ≥2.

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_data`  in  8  byte from arbiter `dout`; ignored when `in_valid`=0
- `in_valid`  in  1  arbiter `valid`; one byte accepted per high cycle, unconditionally
- `flush`  in  1  emit the partial word currently accumulated
- `out_ready`  in  1  downstream accepts the head word
- `out_data`  out  32  head word; byte k occupies bits [8k+7:8k]
- `out_cnt`  out  3  number of valid bytes in head word, 1..4
- `out_valid`  out  1  FIFO non-empty
- `overflow`  out  1  sticky; a word was dropped since reset

## Operation
- Accumulator:
  - holds `acc[31:0]` and `cnt[1:0]`.
  - On `in_valid`, the byte is written to lane `cnt`, then `cnt` increments.
- Word complete: when `in_valid` arrives with `cnt`==3, push {acc with new byte, 4}. `cnt` returns to 0.
- Flush:
  - when `flush`=1 and the effective count is ≥1, push {acc, count}. The effective count includes any byte arriving in the same cycle.
  - Unused lanes of a flushed word are 0.
  - `cnt` returns to 0.
- Flush with effective count 0 is a no-op.
- `flush` coinciding with a completing 4th byte pushes exactly one word, with `out_cnt`=4.
- Accumulator lanes are cleared to 0 on every push, so partial words never carry stale bytes.
- Output FIFO:
  - push as above; pop when `out_valid && out_ready`.
  - Push into a full FIFO succeeds only if a pop happens in the same cycle.
  - Otherwise the word is dropped, `overflow` is set, and the accumulator still clears.
- `overflow` is cleared only by reset.
- Simultaneous push and pop on a non-empty FIFO leaves occupancy unchanged.

## Timing
- Reset (async assert, sync-to-clock release by the integrator):
  - `out_data`=0, `out_cnt`=0, `out_valid`=0, `overflow`=0.
  - Accumulator empty, FIFO pointers 0.
- Reset mid-word discards accumulated bytes and all FIFO contents.
- Latency:
  - a byte completing a word at edge N gives `out_valid`=1 with that word after edge N.
  - Same for a flush sampled at edge N.
- `out_data`/`out_cnt` are driven from FIFO storage and stay stable while `out_valid`=1 and `out_ready`=0.
- Pop at edge N presents the next entry, or drops `out_valid`, after edge N.
- `out_ready` with `out_valid`=0 has no effect.
- Sustained rate: one byte per cycle in, one word per 4 cycles out. `out_ready` held high never overflows.
- Pointers are log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ and LSBs equal.

## Structure
- Package `arb_byte_packer_pkg`:
  - `BYTES`, `CNT_W`=3
  - packed struct `pack_entry_t` {`logic [2:0] cnt; logic [31:0] data;`}
- Sub-module `pack_fifo`:
  - generic synchronous FIFO of `pack_entry_t`, parameter `DEPTH`.
  - Ports: push/pop/full/empty/head.
  - Push when full is ignored internally; the overflow decision lives in the top.
- Top: accumulator, push/flush logic, overflow flag, FIFO instance.

## Test plan
- Bytes 87,89,91,93 on consecutive cycles, `out_ready`=1 -> one word `out_data`=0x5D5B5957, `out_cnt`=4, `out_valid` for 1 cycle after 4th edge.
- Bytes 1..6, then `flush` -> words 0x04030201 (cnt 4) and 0x00000605 (cnt 2); a second `flush` with nothing pending produces no word.
- `out_ready`=0, 12 bytes -> first two words held, third dropped, `overflow`=1 and stays 1. Raising `out_ready` drains exactly 2 words in order.
- FIFO full, 4th byte completing a word in the same cycle as `out_ready`=1 -> push accepted, `overflow` stays 0, occupancy stays 2.
- `flush` in the same cycle as a byte with `cnt`=1 -> one word, `out_cnt`=2, with both bytes present.
- Reset asserted asynchronously after 2 bytes, with one word queued -> all outputs 0 immediately. After release, 4 new bytes produce a word containing only the new bytes.

Source files
------------

// File: rtl/arb_byte_packer_pkg.sv
// Shared types and constants for the arbiter byte packer.
package arb_byte_packer_pkg;

  localparam int BYTES = 4;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [CNT_W-1:0]   cnt;
    logic [8*BYTES-1:0] data;
  } pack_entry_t;

endpackage

// File: rtl/pack_fifo.sv
// Small synchronous FIFO of packed words. Pointers carry one extra wrap bit so
// full and empty can be told apart without a separate occupancy counter.
// A push into a full FIFO is accepted only when a pop frees a slot on the same
// edge; otherwise it is silently ignored (the caller accounts for the loss).
module pack_fifo
  import arb_byte_packer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  pack_entry_t push_data_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output pack_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  pack_entry_t   mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; both wrap naturally at 2*DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/arb_byte_packer.sv
// Packs the arbiter's byte stream little-endian into 32-bit words and queues
// them for a ready/valid consumer. The arbiter cannot be stalled, so a word
// that finds the queue full (with no pop on the same edge) is dropped and the
// sticky overflow flag records it.
module arb_byte_packer
  import arb_byte_packer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  input  logic                flush,
  input  logic                out_ready,
  output logic [8*BYTES-1:0]  out_data,
  output logic [CNT_W-1:0]    out_cnt,
  output logic                out_valid,
  output logic                overflow
);

  logic [8*BYTES-1:0] acc_q, acc_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               overflow_q, overflow_d;

  logic [8*BYTES-1:0] acc_with_byte;
  logic [CNT_W-1:0]   eff_cnt;
  logic               push;
  logic               pop;
  logic               push_ok;
  logic               fifo_full;
  logic               fifo_empty;
  pack_entry_t        push_entry;
  pack_entry_t        head;

  // Accumulator view including a byte arriving this cycle, and push decision.
  // A flush that coincides with the 4th byte yields one word of count 4.
  always_comb begin
    acc_with_byte = acc_q;
    if (in_valid) acc_with_byte[{cnt_q, 3'b000} +: 8] = in_data;
    eff_cnt   = {1'b0, cnt_q} + {2'b00, in_valid};
    push      = (in_valid && (cnt_q == 2'd3)) || (flush && (eff_cnt != '0));
    push_entry.cnt  = eff_cnt;
    push_entry.data = acc_with_byte;
    pop       = !fifo_empty && out_ready;
    push_ok   = push && (!fifo_full || pop);
  end

  // Accumulator and overflow next state; lanes clear on every push, dropped or not.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (push) begin
      acc_d = '0;
      cnt_d = 2'd0;
      if (!push_ok) overflow_d = 1'b1;
    end else if (in_valid) begin
      acc_d = acc_with_byte;
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Accumulator and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  pack_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_ok),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head)
  );

  // Head is masked while empty so idle and reset outputs read as zero.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : head.data;
  assign out_cnt   = fifo_empty ? '0 : head.cnt;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_arb_byte_packer.sv
// Directed bench for arb_byte_packer: a queue-based reference model checked on
// every cycle, plus literal expectations at key points of each scenario.
module tb_arb_byte_packer;
  import arb_byte_packer_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_cnt;
  logic        out_valid;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  arb_byte_packer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .flush    (flush),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_cnt  (out_cnt),
    .out_valid(out_valid),
    .overflow (overflow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: pending bytes, queued words, sticky loss flag.
  logic [7:0]  m_bytes[$];
  logic [34:0] exp_q[$];   // {cnt[2:0], data[31:0]}
  logic        m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bytes.delete();
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      logic        do_pop;
      logic        do_push;
      logic [31:0] w;
      logic [2:0]  c;
      do_pop = (exp_q.size() > 0) && out_ready;
      if (in_valid) m_bytes.push_back(in_data);
      do_push = (m_bytes.size() == 4) || (flush && m_bytes.size() > 0);
      w = '0;
      c = 3'(m_bytes.size());
      if (do_push) begin
        foreach (m_bytes[i]) w[8*i +: 8] = m_bytes[i];
        m_bytes.delete();
      end
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({c, w});
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    check("cyc_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("cyc_overflow", 32'(overflow), 32'(m_ovf));
    if (exp_q.size() > 0) begin
      check("cyc_data", out_data, exp_q[0][31:0]);
      check("cyc_cnt", 32'(out_cnt), 32'(exp_q[0][34:32]));
    end
  end

  // Driver: one cycle of inputs, applied just after the falling edge.
  task automatic cyc(input logic iv, input logic [7:0] d, input logic fl, input logic rdy);
    @(negedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = rdy;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_cnt", 32'(out_cnt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Four consecutive bytes, ready held high
    cyc(1, 8'd87, 0, 1);
    cyc(1, 8'd89, 0, 1);
    cyc(1, 8'd91, 0, 1);
    cyc(1, 8'd93, 0, 1);
    cyc(0, 8'd0, 0, 1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", out_data, 32'h5D5B5957);
    check("t1_cnt", 32'(out_cnt), 32'd4);
    cyc(0, 8'd0, 0, 0);
    check("t1_gone", 32'(out_valid), 32'd0);

    // Bytes 1..6 then flush
    for (int i = 1; i <= 6; i++) cyc(1, 8'(i), 0, 0);
    cyc(0, 8'd0, 1, 0);
    cyc(0, 8'd0, 0, 0);
    check("t2_w0", out_data, 32'h04030201);
    check("t2_c0", 32'(out_cnt), 32'd4);
    cyc(0, 8'd0, 0, 1);
    cyc(0, 8'd0, 1, 1);   // empty flush while popping the last word
    check("t2_w1", out_data, 32'h00000605);
    check("t2_c1", 32'(out_cnt), 32'd2);
    cyc(0, 8'd0, 0, 0);
    check("t2_noop_flush", 32'(out_valid), 32'd0);

    // Flush together with the second byte
    cyc(1, 8'hAA, 0, 0);
    cyc(1, 8'hBB, 1, 0);
    cyc(0, 8'd0, 0, 0);
    check("t5_data", out_data, 32'h0000BBAA);
    check("t5_cnt", 32'(out_cnt), 32'd2);
    cyc(0, 8'd0, 0, 1);
    cyc(0, 8'd0, 0, 0);
    check("t5_gone", 32'(out_valid), 32'd0);

    // Full FIFO, completing byte coincides with a pop
    for (int i = 0; i < 11; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    cyc(1, 8'h2B, 0, 1);
    cyc(0, 8'd0, 0, 0);
    check("t4_ovf", 32'(overflow), 32'd0);
    check("t4_head", out_data, 32'h27262524);
    cyc(0, 8'd0, 0, 1);
    cyc(0, 8'd0, 0, 1);
    check("t4_second", out_data, 32'h2B2A2928);
    cyc(0, 8'd0, 0, 0);
    check("t4_empty", 32'(out_valid), 32'd0);

    // Twelve bytes with no ready: third word dropped
    for (int i = 0; i < 12; i++) cyc(1, 8'(8'h30 + i), 0, 0);
    cyc(0, 8'd0, 0, 0);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_head", out_data, 32'h33323130);
    cyc(0, 8'd0, 0, 0);
    check("t3_held", out_data, 32'h33323130);
    cyc(0, 8'd0, 0, 1);
    cyc(0, 8'd0, 0, 1);
    check("t3_second", out_data, 32'h37363534);
    cyc(0, 8'd0, 0, 0);
    check("t3_drained", 32'(out_valid), 32'd0);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset with a word queued and two bytes pending
    for (int i = 0; i < 6; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    cyc(0, 8'd0, 0, 0);
    check("t6_pre", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", out_data, 32'd0);
    check("t6_rst_cnt", 32'(out_cnt), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h50 + i), 0, 0);
    cyc(0, 8'd0, 0, 0);
    check("t6_new", out_data, 32'h53525150);
    check("t6_new_cnt", 32'(out_cnt), 32'd4);
    cyc(0, 8'd0, 0, 1);
    cyc(0, 8'd0, 0, 0);
    cyc(0, 8'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
